// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// alu_rr_arbiter: round-robin req/ack front end sharing one ALU between two ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_rr_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [2:0]   opc0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         req1,
  input  logic [2:0]   opc1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [N-1:0] res,
  output logic         zero,
  output logic         neg,
  output logic         err,
  output logic         busy,
  output logic [2:0]   alu_opc,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_w,
  input  logic         alu_zero,
  input  logic         alu_neg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic           prio_q;
  logic           gnt_q;
  logic [2:0]     opc_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   res_q;
  logic           zero_q;
  logic           neg_q;
  logic           err_q;
  logic           ack0_q;
  logic           ack1_q;
  logic           busy_q;

  logic           gnt_d;
  logic           illegal_w;

  // Port 1 wins when it is the only requester, or on a tie when it holds priority.
  assign gnt_d     = req1 & (~req0 | prio_q);
  assign illegal_w = (opc_q[2:1] == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            gnt_q   <= gnt_d;
            opc_q   <= gnt_d ? opc1 : opc0;
            a_q     <= gnt_d ? a1 : a0;
            b_q     <= gnt_d ? b1 : b0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes leave the ALU output floating, so it is never sampled.
          if (illegal_w) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            res_q  <= alu_w;
            zero_q <= alu_zero;
            neg_q  <= alu_neg;
            err_q  <= 1'b0;
          end
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= RESP;
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          prio_q  <= ~gnt_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign res     = res_q;
  assign zero    = zero_q;
  assign neg     = neg_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign alu_opc = opc_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// ============================================================================
// tb_alu_rr_arbiter: scoreboard bench for alu_rr_arbiter with a behavioural ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_rr_arbiter;
  localparam int N = 32;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_SLT = 3'b100, OP_XOR = 3'b101;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [2:0]   opc0, opc1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, zero, neg, err, busy;
  logic [N-1:0] res;
  logic [2:0]   alu_opc;
  logic [N-1:0] alu_a, alu_b, alu_w;
  logic         alu_zero, alu_neg;

  alu_rr_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .opc0(opc0), .a0(a0), .b0(b0),
    .req1(req1), .opc1(opc1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res(res), .zero(zero), .neg(neg), .err(err),
    .busy(busy), .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] alu_ref(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU; illegal opcodes produce junk standing in for a floating bus.
  always_comb begin
    alu_w    = alu_ref(alu_opc, alu_a, alu_b);
    alu_zero = (alu_w == '0);
    alu_neg  = alu_w[N-1];
    if (alu_opc[2:1] == 2'b11) begin
      alu_w    = 32'hDEAD_BEEF;
      alu_zero = 1'b0;
      alu_neg  = 1'b1;
    end
  end

  typedef struct packed {
    logic [N-1:0] res;
    logic         zero;
    logic         neg;
    logic         err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_ports[$];
  int   ack_cycles[$];

  function automatic exp_t expect_of(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (op[2:1] == 2'b11) begin
      e.res = '0; e.zero = 1'b1; e.neg = 1'b0; e.err = 1'b1;
    end else begin
      e.res = alu_ref(op, a, b); e.zero = (e.res == '0); e.neg = e.res[N-1]; e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_ack(input string port, input exp_t e);
    check_eq({port, "_res"},  64'(res),  64'(e.res));
    check_eq({port, "_zero"}, 64'(zero), 64'(e.zero));
    check_eq({port, "_neg"},  64'(neg),  64'(e.neg));
    check_eq({port, "_err"},  64'(err),  64'(e.err));
    check_eq({port, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Scoreboard: pop and compare whenever an ack is observed.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 && ack1) check_eq("ack_overlap", 64'd1, 64'd0);
      if (ack0) begin
        ack_ports.push_back(0); ack_cycles.push_back(cyc);
        if (q0.size() == 0) check_eq("spurious_ack0", 64'd1, 64'd0);
        else compare_ack("p0", q0.pop_front());
      end
      if (ack1) begin
        ack_ports.push_back(1); ack_cycles.push_back(cyc);
        if (q1.size() == 0) check_eq("spurious_ack1", 64'd1, 64'd0);
        else compare_ack("p1", q1.pop_front());
      end
    end
  end

  task automatic issue(input int p, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, output int lat);
    int  start;
    bit  got;
    got = 0;
    if (p == 0) begin
      q0.push_back(expect_of(op, a, b)); opc0 = op; a0 = a; b0 = b; req0 = 1'b1;
    end else begin
      q1.push_back(expect_of(op, a, b)); opc1 = op; a1 = a; b1 = b; req1 = 1'b1;
    end
    start = cyc;
    lat   = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        got = 1; lat = cyc - start;
        break;
      end
    end
    if (!got) check_eq("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_ack0"}, 64'(ack0), 64'd0);
    check_eq({tag, "_ack1"}, 64'(ack1), 64'd0);
    check_eq({tag, "_res"},  64'(res),  64'd0);
    check_eq({tag, "_zero"}, 64'(zero), 64'd0);
    check_eq({tag, "_neg"},  64'(neg),  64'd0);
    check_eq({tag, "_err"},  64'(err),  64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_aopc"}, 64'(alu_opc), 64'd0);
    check_eq({tag, "_aa"},   64'(alu_a), 64'd0);
    check_eq({tag, "_ab"},   64'(alu_b), 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, lat1;
    rst = 1'b1; req0 = 0; req1 = 0; opc0 = 0; opc1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clk);
    #1 check_cleared("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single uncontended request.
    issue(0, OP_ADD, 32'd5, 32'd7, lat);
    check_eq("single_latency", 64'(lat), 64'd2);

    // Simultaneous requests right after reset: port 0 first.
    pulse_reset();
    ack_ports.delete(); ack_cycles.delete();
    fork
      issue(0, OP_SUB, 32'd3, 32'd3, lat);
      issue(1, OP_SUB, 32'd2, 32'd5, lat1);
    join
    check_eq("simul_order0", 64'(ack_ports[0]), 64'd0);
    check_eq("simul_order1", 64'(ack_ports[1]), 64'd1);

    // Continuous contention: grants alternate, 3 cycles apart.
    ack_ports.delete(); ack_cycles.delete();
    fork
      begin
        int l;
        issue(0, OP_ADD, 32'd10, 32'd20, l);
        issue(0, OP_XOR, 32'hFF00, 32'h0FF0, l);
      end
      begin
        int l;
        issue(1, OP_AND, 32'hF0F0, 32'hFF00, l);
        issue(1, OP_SUB, 32'd0, 32'd1, l);
      end
    join
    check_eq("cont_count", 64'(ack_ports.size()), 64'd4);
    for (int i = 0; i < 4 && i < ack_ports.size(); i++) begin
      check_eq("cont_order", 64'(ack_ports[i]), 64'(i % 2));
      if (i > 0) check_eq("cont_spacing", 64'(ack_cycles[i] - ack_cycles[i-1]), 64'd3);
    end

    // Illegal opcode followed by a legal one clearing err.
    issue(1, 3'b111, 32'h1234, 32'h5678, lat);
    issue(1, OP_OR, 32'hF0, 32'h0F, lat);
    issue(0, 3'b110, 32'd1, 32'd1, lat);

    // SLT and wrap-around.
    issue(0, OP_SLT, 32'd1, 32'd2, lat);
    issue(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, lat);
    issue(0, OP_SLT, 32'd7, 32'd3, lat);
    issue(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, lat);
    issue(0, OP_AND, 32'hFF, 32'h3C, lat);

    // Reset while in EXEC: the in-flight port 0 op is dropped.
    opc0 = OP_ADD; a0 = 32'd1; b0 = 32'd2; req0 = 1'b1;
    @(posedge clk); #1;
    check_eq("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1 check_cleared("midop");
    req0 = 1'b0;
    opc1 = OP_SUB; a1 = 32'd9; b1 = 32'd4; req1 = 1'b1;
    @(posedge clk); #1;
    check_eq("in_reset_ack", 64'({ack0, ack1}), 64'd0);
    rst = 1'b0;
    issue(1, OP_SUB, 32'd9, 32'd4, lat);
    check_eq("post_reset_latency", 64'(lat), 64'd2);

    repeat (4) @(posedge clk);
    #1;
    check_eq("q0_drained", 64'(q0.size()), 64'd0);
    check_eq("q1_drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
